acondiciona_botones: RTL and testbench

- Conditions the two raw push-buttons (increment/decrement) for the year counter.
- Per button, in order: 2-flop synchroniser, debounce filter, press-edge detector, hold auto-repeat.
- Outputs are single-cycle, mutually exclusive pulses that connect directly to the counter's boton_aumenta/boton_disminuye inputs.

---
 rtl/acondiciona_pkg.sv | 35 +++
 rtl/acondiciona_botones_filtro.sv | 110 +++++++++++
 rtl/acondiciona_botones.sv | 84 ++++++++
 tb/tb_acondiciona_botones.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/acondiciona_pkg.sv
// Shared types and timing defaults for push-button conditioning.
// Imported by boton_filtro and acondiciona_botones.
package acondiciona_pkg;

  typedef enum logic [1:0] {
    SUELTO,
    ESPERA,
    REPITE
  } estado_boton_t;

  localparam int unsigned DEF_DEBOUNCE = 500000;
  localparam int unsigned DEF_DELAY    = 25000000;
  localparam int unsigned DEF_PERIOD   = 5000000;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // ceil(log2(v)); callers pass max+1 to get a width that holds max
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/acondiciona_botones_filtro.sv
// One button: synchroniser, debounce, press edge and hold auto-repeat.
// pulso is combinational; the top registers it.
module boton_filtro
  import acondiciona_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_PERIOD,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic hold_inhibit,
  output logic pulso,
  output logic estable
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DL_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       r_sync;
  logic             r_estable;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  estado_boton_t    r_estado;

  estado_boton_t    w_estado_sig;
  logic [CNT_W-1:0] w_rep_sig;
  logic             w_pulso;
  logic             w_difiere;
  logic             w_db_fin;
  logic             w_sube;
  logic             w_baja;

  assign w_difiere = r_sync[1] != r_estable;
  assign w_db_fin  = w_difiere && (r_db_cnt == DB_LAST);
  assign w_sube    = w_db_fin && !r_estable;
  assign w_baja    = w_db_fin && r_estable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_estable <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      if (!w_difiere || w_db_fin) r_db_cnt <= '0;
      else                        r_db_cnt <= r_db_cnt + CNT_W'(1);
      if (w_db_fin) r_estable <= !r_estable;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= SUELTO;
      r_rep_cnt <= '0;
    end else begin
      r_estado  <= w_estado_sig;
      r_rep_cnt <= w_rep_sig;
    end
  end

  // Release beats a coincident repeat; both-held freezes the count
  always_comb begin
    w_estado_sig = r_estado;
    w_rep_sig    = r_rep_cnt;
    w_pulso      = 1'b0;
    unique case (r_estado)
      SUELTO: begin
        if (w_sube) begin
          w_estado_sig = ESPERA;
          w_rep_sig    = '0;
          w_pulso      = 1'b1;
        end
      end
      ESPERA: begin
        if (w_baja) begin
          w_estado_sig = SUELTO;
        end else if (!hold_inhibit) begin
          if (r_rep_cnt == DL_LAST) begin
            w_estado_sig = REPITE;
            w_rep_sig    = '0;
            w_pulso      = 1'b1;
          end else begin
            w_rep_sig = r_rep_cnt + CNT_W'(1);
          end
        end
      end
      REPITE: begin
        if (w_baja) begin
          w_estado_sig = SUELTO;
        end else if (!hold_inhibit) begin
          if (r_rep_cnt == PR_LAST) begin
            w_rep_sig = '0;
            w_pulso   = 1'b1;
          end else begin
            w_rep_sig = r_rep_cnt + CNT_W'(1);
          end
        end
      end
      default: w_estado_sig = SUELTO;
    endcase
  end

  assign pulso   = w_pulso;
  assign estable = r_estable;

endmodule

// File: rtl/acondiciona_botones.sv
// Conditions up/down buttons into one-cycle, mutually exclusive pulses
// for the year counter; increment wins a same-cycle tie.
module acondiciona_botones
  import acondiciona_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_PERIOD,
  parameter int unsigned CNT_W           =
    clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic boton_aumenta,
  output logic boton_disminuye,
  output logic up_estable,
  output logic down_estable
);

  logic w_pulso_up;
  logic w_pulso_dn;
  logic w_est_up;
  logic w_est_dn;
  logic w_aum;
  logic w_dis;
  logic r_aum;
  logic r_dis;

  boton_filtro #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_up (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_up_raw),
    .hold_inhibit(w_est_dn),
    .pulso       (w_pulso_up),
    .estable     (w_est_up)
  );

  boton_filtro #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_dn (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_down_raw),
    .hold_inhibit(w_est_up),
    .pulso       (w_pulso_dn),
    .estable     (w_est_dn)
  );

  always_comb begin
    w_aum = 1'b0;
    w_dis = 1'b0;
    priority case (1'b1)
      w_pulso_up: w_aum = 1'b1;
      w_pulso_dn: w_dis = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aum <= 1'b0;
      r_dis <= 1'b0;
    end else begin
      r_aum <= w_aum;
      r_dis <= w_dis;
    end
  end

  assign boton_aumenta   = r_aum;
  assign boton_disminuye = r_dis;
  assign up_estable      = w_est_up;
  assign down_estable    = w_est_dn;

endmodule

// File: tb/tb_acondiciona_botones.sv
// Directed bench for acondiciona_botones with D=4, delay=10, period=3.
// Vectors are bit masks indexed by edge number after reset release.
module tb_acondiciona_botones;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_up_raw;
  logic btn_down_raw;
  logic boton_aumenta;
  logic boton_disminuye;
  logic up_estable;
  logic down_estable;

  int n_chk  = 0;
  int n_fail = 0;

  acondiciona_botones #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .btn_up_raw     (btn_up_raw),
    .btn_down_raw   (btn_down_raw),
    .boton_aumenta  (boton_aumenta),
    .boton_disminuye(boton_disminuye),
    .up_estable     (up_estable),
    .down_estable   (down_estable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = a; i < b; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] ev(input int k);
    return 64'd1 << k;
  endfunction

  task automatic do_reset();
    reset_n      = 1'b0;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // rst_e > 0: reset asserted just after edge rst_e, released before rst_e+3
  task automatic run_case(
    input string nm, input int n,
    input logic [63:0] ur, input logic [63:0] dr,
    input logic [63:0] eu, input logic [63:0] ed,
    input logic [63:0] su, input logic [63:0] sd,
    input int rst_e
  );
    do_reset();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      btn_up_raw   = ur[k];
      btn_down_raw = dr[k];
      if (rst_e > 0 && k == rst_e + 3) reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("%s.aum@%0d", nm, k), boton_aumenta, eu[k]);
      chk($sformatf("%s.dis@%0d", nm, k), boton_disminuye, ed[k]);
      chk($sformatf("%s.upst@%0d", nm, k), up_estable, su[k]);
      chk($sformatf("%s.dnst@%0d", nm, k), down_estable, sd[k]);
      if (k == rst_e) begin
        reset_n = 1'b0;
        #1;
        chk($sformatf("%s.rst_aum", nm), boton_aumenta, 1'b0);
        chk($sformatf("%s.rst_dis", nm), boton_disminuye, 1'b0);
        chk($sformatf("%s.rst_upst", nm), up_estable, 1'b0);
        chk($sformatf("%s.rst_dnst", nm), down_estable, 1'b0);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    #2;
    chk("reset.aum", boton_aumenta, 1'b0);
    chk("reset.dis", boton_disminuye, 1'b0);
    chk("reset.upst", up_estable, 1'b0);
    chk("reset.dnst", down_estable, 1'b0);

    // clean press; debounced release lands on the would-be repeat edge 16
    run_case("press", 24, rng(1, 11), '0,
             ev(6), '0, rng(6, 16), '0, 0);

    // bounce shorter than the debounce window
    run_case("bounce", 16, rng(1, 3) | rng(5, 7), '0,
             '0, '0, '0, '0, 0);

    // auto-repeat; release lands on would-be repeat edge 34
    run_case("repeat", 40, '0, rng(1, 29),
             '0,
             ev(6) | ev(16) | ev(19) | ev(22) | ev(25) | ev(28) | ev(31),
             '0, rng(6, 34), 0);

    // both held: increment wins, no repeats
    run_case("both", 40, rng(1, 26), rng(1, 26),
             ev(6), '0, rng(6, 31), rng(6, 31), 0);

    // reset mid-hold: new press 6 edges after release (edge 22)
    run_case("reset", 40, rng(1, 64), '0,
             ev(6) | ev(22) | ev(32) | ev(35) | ev(38), '0,
             rng(6, 15) | rng(22, 64), '0, 14);

    // release during repeat, then a fresh press
    run_case("release", 44, rng(1, 14) | rng(24, 34), '0,
             ev(6) | ev(16) | ev(29), '0,
             rng(6, 19) | rng(29, 39), '0, 0);

    // down released while both held: up repeat resumes from held count
    run_case("resume", 50, rng(1, 40), rng(1, 11),
             ev(6) | ev(26) | ev(29) | ev(32) | ev(35) | ev(38)
               | ev(41) | ev(44),
             '0, rng(6, 45), rng(6, 16), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
